// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone classic initiator moving a block of 32-bit words, one single-word cycle per word.
module wb_burst_master #(
    parameter int LEN_BITS       = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_BITS        = 11
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [31:0]         cmd_addr,
    input  logic [LEN_BITS-1:0] cmd_len,
    input  logic                cmd_we,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [31:0]         wr_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [31:0]         rd_data,
    output logic                done_valid,
    output logic [1:0]          done_status,
    output logic [LEN_BITS:0]   done_count,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [31:0]         wb_adr_o,
    output logic [3:0]          wb_sel_o,
    output logic [31:0]         wb_dat_o,
    input  logic [31:0]         wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_BUS, S_RD_OUT, S_NEXT, S_DONE} state_t;
    state_t              r_state, w_next;
    logic [31:0]         r_addr, r_wdat, r_rdat;
    logic [LEN_BITS-1:0] r_len;
    logic                r_we;
    logic [LEN_BITS:0]   r_cnt;
    logic [1:0]          r_status;
    logic [TO_BITS-1:0]  r_to;
    logic                w_last, w_tmo;

    assign w_last = r_cnt == {1'b0, r_len};
    assign w_tmo  = r_to == TO_BITS'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = cmd_valid ? (cmd_we ? S_FETCH : S_BUS) : S_IDLE;
            S_FETCH:  w_next = wr_valid ? S_BUS : S_FETCH;
            S_BUS:    w_next = wb_ack_i ? (r_we ? S_NEXT : S_RD_OUT) : ((wb_err_i || w_tmo) ? S_DONE : S_BUS);
            S_RD_OUT: w_next = rd_ready ? S_NEXT : S_RD_OUT;
            S_NEXT:   w_next = w_last ? S_DONE : (r_we ? S_FETCH : S_BUS);
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = r_state == S_IDLE;
        wr_ready   = r_state == S_FETCH;
        rd_valid   = r_state == S_RD_OUT;
        done_valid = r_state == S_DONE;
        wb_cyc_o   = r_state == S_BUS;
        wb_stb_o   = r_state == S_BUS;
        wb_we_o    = (r_state == S_BUS) && r_we;
    end

    assign wb_adr_o    = r_addr;
    assign wb_dat_o    = r_wdat;
    assign wb_sel_o    = 4'hF;
    assign rd_data     = r_rdat;
    assign done_status = r_status;
    assign done_count  = r_cnt;

    // ACK wins over ERR; a failed or timed-out word never reaches NEXT, so it is not counted
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_addr   <= '0;
            r_wdat   <= '0;
            r_rdat   <= '0;
            r_len    <= '0;
            r_we     <= 1'b0;
            r_cnt    <= '0;
            r_status <= 2'b00;
            r_to     <= '0;
        end else begin
            r_to <= (r_state == S_BUS) ? r_to + 1'b1 : '0;
            if (r_state == S_IDLE && cmd_valid) begin
                r_addr <= cmd_addr & 32'hFFFF_FFFC;
                r_len  <= cmd_len;
                r_we   <= cmd_we;
                r_cnt  <= '0;
            end
            if (r_state == S_FETCH && wr_valid) r_wdat <= wr_data;
            if (r_state == S_BUS && wb_ack_i && !r_we) r_rdat <= wb_dat_i;
            if (r_state == S_BUS && !wb_ack_i && (wb_err_i || w_tmo)) r_status <= wb_err_i ? 2'b01 : 2'b10;
            if (r_state == S_NEXT) begin
                r_cnt  <= r_cnt + 1'b1;
                r_addr <= r_addr + 32'd4;
                if (w_last) r_status <= 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: directed table plus randomized bursts against a word-list reference model.
module tb_wb_burst_master;
    localparam int LB = 4, TMO = 20, TOB = 5;
    logic          clk = 1'b0, rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0]   cmd_addr = '0;
    logic [LB-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0, wr_ready, rd_valid, rd_ready = 1'b0, done_valid;
    logic [31:0]   wr_data = '0, rd_data;
    logic [1:0]    done_status;
    logic [LB:0]   done_count;
    logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i = 1'b0, wb_err_i = 1'b0;
    logic [31:0]   wb_adr_o, wb_dat_o, wb_dat_i = '0;
    logic [3:0]    wb_sel_o;

    always #5 clk = ~clk;

    wb_burst_master #(.LEN_BITS(LB), .TIMEOUT_CYCLES(TMO), .TO_BITS(TOB)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_we(cmd_we),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done_valid(done_valid), .done_status(done_status), .done_count(done_count),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    int checks = 0, passes = 0;
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // responder configuration and bus observations
    int          lat = 0, err_word = -1, resp_n = 0, stb_cnt = 0;
    bit          silent = 0, noise = 0, both = 0;
    logic [31:0] salt = '0;
    logic [31:0] log_adr[$], log_dat[$];
    logic        log_we[$];
    int          cyc_n = 0, first_stb = -1, first_ack = -1, first_rv = -1, last_run = 0, run = 0;
    int          gap_viol = 0, stall_viol = 0, done_n = 0;
    bit          prev_stb = 0, prev_resp = 0, prev_rv = 0, done_after_stb = 0;
    logic [31:0] prev_rd = '0;

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (prev_resp && wb_stb_o) gap_viol++;
        if (wb_cyc_o != wb_stb_o || wb_sel_o != 4'hF || wb_adr_o[1:0] != 2'b00) gap_viol++;
        if (prev_rv && rd_valid && rd_data != prev_rd) stall_viol++;
        if (rd_valid && wb_stb_o) stall_viol++;
        if (rd_valid && first_rv < 0) first_rv = cyc_n;
        if (wb_stb_o && first_stb < 0) first_stb = cyc_n;
        if (wb_stb_o) run++;
        else begin
            if (prev_stb) last_run = run;
            run = 0;
        end
        if (done_valid) begin
            done_n++;
            done_after_stb = prev_stb;
        end
        prev_stb = wb_stb_o;
        prev_rv  = rd_valid;
        prev_rd  = rd_data;
        prev_resp = 0;
        wb_ack_i = 0;
        wb_err_i = 0;
        if (wb_stb_o) begin
            if (!silent && stb_cnt == lat) begin
                prev_resp = 1;
                if (resp_n == err_word) wb_err_i = 1;
                else begin
                    wb_ack_i = 1;
                    wb_err_i = both && ($urandom % 2 == 1);
                    wb_dat_i = wb_adr_o ^ salt;
                    if (first_ack < 0) first_ack = cyc_n;
                    log_adr.push_back(wb_adr_o);
                    log_we.push_back(wb_we_o);
                    log_dat.push_back(wb_we_o ? wb_dat_o : wb_adr_o ^ salt);
                end
                resp_n++;
            end
            stb_cnt++;
        end else begin
            stb_cnt = 0;
            if (noise) begin
                wb_ack_i = ($urandom % 2 == 1);
                wb_err_i = ($urandom % 2 == 1);
                wb_dat_i = $urandom;
            end
        end
    end

    logic [1:0]  g_status;
    int          g_count;
    logic [31:0] g_a0, g_al, g_d0;

    task automatic run_burst(input logic [31:0] addr, input int len, input bit we, input int l, input int ew,
                             input bit sil, input int rdm, input bit wrr, input logic [31:0] s, input bit rnd);
        logic [31:0] wd[$];
        logic [31:0] got[$];
        logic [31:0] ea;
        int n, k, wi, rvc, acc, dc, budget;
        bit fin;
        logic [1:0] est;
        n = len + 1;
        for (int i = 0; i < n; i++) wd.push_back(rnd ? $urandom : 32'(i + 1));
        lat = l; err_word = ew; silent = sil; salt = s; noise = rnd; both = rnd; resp_n = 0;
        log_adr.delete(); log_dat.delete(); log_we.delete();
        first_stb = -1; first_ack = -1; first_rv = -1; last_run = 0; gap_viol = 0; stall_viol = 0; done_after_stb = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_addr = addr; cmd_len = LB'(len); cmd_we = we;
        @(posedge clk);
        #1 acc = cyc_n;
        cmd_valid = 0;
        wi = 0; rvc = 0; fin = 0; budget = 0; dc = 0; g_status = 2'b11; g_count = -1;
        while (!fin && budget < 3000) begin
            @(negedge clk);
            budget++;
            wr_valid = wrr ? ($urandom % 2 == 1) : 1'b1;
            wr_data = wd[wi < n ? wi : n - 1];
            if (wr_ready && wr_valid) wi++;
            rd_ready = (rdm == 0) ? 1'b1 : (rdm < 0 ? ($urandom % 2 == 1) : (rd_valid && rvc >= rdm));
            if (rd_valid) rvc++;
            if (rd_valid && rd_ready) begin
                got.push_back(rd_data);
                rvc = 0;
            end
            if (done_valid) begin
                fin = 1; g_status = done_status; g_count = int'(done_count); dc = cyc_n;
            end
        end
        wr_valid = 0; rd_ready = 0;
        chk("done seen", 64'(fin), 64'(1));
        if (fin) begin
            @(negedge clk);
            chk("done one-cycle", 64'(done_valid), 64'(0));
            chk("ready after done", 64'(cmd_ready), 64'(1));
        end
        noise = 0; both = 0;
        k = sil ? 0 : ((ew >= 0 && ew < n) ? ew : n);
        est = sil ? 2'b10 : (k < n ? 2'b01 : 2'b00);
        chk("status", 64'(g_status), 64'(est));
        chk("count", 64'(g_count), 64'(k));
        chk("bus words", 64'(log_adr.size()), 64'(k));
        for (int i = 0; i < k && i < log_adr.size(); i++) begin
            ea = (addr & 32'hFFFF_FFFC) + 32'(4 * i);
            chk("adr", 64'(log_adr[i]), 64'(ea));
            chk("we", 64'(log_we[i]), 64'(we));
            if (we) chk("wdata", 64'(log_dat[i]), 64'(wd[i]));
        end
        if (!we) begin
            chk("rd words", 64'(got.size()), 64'(k));
            for (int i = 0; i < k && i < got.size(); i++) begin
                ea = (addr & 32'hFFFF_FFFC) + 32'(4 * i);
                chk("rdata", 64'(got[i]), 64'(ea ^ s));
            end
        end
        chk("stb gap/ctl", 64'(gap_viol), 64'(0));
        chk("rd stall", 64'(stall_viol), 64'(0));
        if (sil) begin
            chk("timeout stb run", 64'(last_run), 64'(TMO));
            chk("done after stb", 64'(done_after_stb), 64'(1));
        end
        if (!we) chk("rd stb latency", 64'(first_stb), 64'(acc));
        if (we && !wrr) chk("wr stb latency", 64'(first_stb), 64'(acc + 1));
        if (!we && k > 0) chk("rd_valid latency", 64'(first_rv), 64'(first_ack + 1));
        if (!sil && k == n && rdm == 0 && !wrr) chk("burst cycles", 64'(dc - acc), 64'(n * (l + 3)));
        g_a0 = log_adr.size() > 0 ? log_adr[0] : '0;
        g_al = log_adr.size() > 0 ? log_adr[log_adr.size() - 1] : '0;
        g_d0 = we ? (log_dat.size() > 0 ? log_dat[0] : '0) : (got.size() > 0 ? got[0] : '0);
    endtask

    typedef struct {
        logic [31:0] addr; int len; bit we; int lat; int ew; bit sil; int rdm; bit wrr; logic [31:0] salt;
        logic [1:0] st; int cnt; logic [31:0] a0; logic [31:0] al; logic [31:0] d0;
    } vec_t;
    vec_t tbl[9];

    initial begin
        int snap, w_len, w_ew, w_rdm;
        tbl[0] = '{32'h13,        0,  0, 2, -1, 0, 0, 0, 32'hDEADBEFF, 2'b00, 1,  32'h10,        32'h10,   32'hDEADBEEF};
        tbl[1] = '{32'h100,       3,  1, 1, -1, 0, 0, 1, 32'h0,        2'b00, 4,  32'h100,       32'h10C,  32'h1};
        tbl[2] = '{32'h200,       3,  0, 0, -1, 0, 5, 0, 32'h0,        2'b00, 4,  32'h200,       32'h20C,  32'h200};
        tbl[3] = '{32'h300,       4,  0, 1, 2,  0, 0, 0, 32'h55,       2'b01, 2,  32'h300,       32'h304,  32'h355};
        tbl[4] = '{32'h400,       1,  0, 1, -1, 1, 0, 0, 32'h0,        2'b10, 0,  32'h0,         32'h0,    32'h0};
        tbl[5] = '{32'hFFFF_FFFC, 1,  0, 1, -1, 0, 0, 0, 32'h0,        2'b00, 2,  32'hFFFF_FFFC, 32'h0,    32'hFFFF_FFFC};
        tbl[6] = '{32'h1000,      15, 1, 0, -1, 0, 0, 0, 32'h0,        2'b00, 16, 32'h1000,      32'h103C, 32'h1};
        tbl[7] = '{32'h500,       2,  1, 2, 0,  0, 0, 0, 32'h0,        2'b01, 0,  32'h0,         32'h0,    32'h0};
        tbl[8] = '{32'h600,       0,  1, 1, -1, 1, 0, 0, 32'h0,        2'b10, 0,  32'h0,         32'h0,    32'h0};

        repeat (3) @(negedge clk);
        chk("rst cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst ctl", 64'({wr_ready, rd_valid, done_valid, wb_cyc_o, wb_stb_o, wb_we_o}), 64'(0));
        chk("rst data", 64'({wb_adr_o, wb_dat_o}), 64'(0));
        chk("rst rd/count", 64'({rd_data, done_count, done_status}), 64'(0));
        chk("rst sel", 64'(wb_sel_o), 64'(4'hF));
        rst_n = 1;
        @(negedge clk);

        foreach (tbl[i]) begin
            run_burst(tbl[i].addr, tbl[i].len, tbl[i].we, tbl[i].lat, tbl[i].ew, tbl[i].sil,
                      tbl[i].rdm, tbl[i].wrr, tbl[i].salt, 1'b0);
            chk("tbl status", 64'(g_status), 64'(tbl[i].st));
            chk("tbl count", 64'(g_count), 64'(tbl[i].cnt));
            if (tbl[i].cnt > 0) begin
                chk("tbl first adr", 64'(g_a0), 64'(tbl[i].a0));
                chk("tbl last adr", 64'(g_al), 64'(tbl[i].al));
                chk("tbl first data", 64'(g_d0), 64'(tbl[i].d0));
            end
        end

        // reset while a word is waiting on a silent responder
        silent = 1; noise = 0; resp_n = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_addr = 32'h800; cmd_len = 3; cmd_we = 0;
        @(posedge clk);
        #1 cmd_valid = 0;
        for (int i = 0; i < 10 && !wb_stb_o; i++) @(negedge clk);
        chk("mid-burst stb", 64'(wb_stb_o), 64'(1));
        repeat (3) @(negedge clk);
        snap = done_n;
        rst_n = 0;
        @(posedge clk);
        #1;
        chk("rst drops cyc/stb", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
        chk("rst idle", 64'(cmd_ready), 64'(1));
        chk("rst adr", 64'(wb_adr_o), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (TMO + 5) @(negedge clk);
        chk("no done after rst", 64'(done_n - snap), 64'(0));
        silent = 0;
        run_burst(32'h900, 2, 0, 1, -1, 0, 0, 0, 32'h1234, 1'b0);

        // cmd_valid held across DONE is only taken once back in IDLE
        lat = 1; err_word = -1; resp_n = 0; salt = '0;
        @(negedge clk);
        cmd_valid = 1; cmd_addr = 32'h40; cmd_len = 0; cmd_we = 0; rd_ready = 1;
        @(negedge clk);
        for (int i = 0; i < 50 && !done_valid; i++) @(negedge clk);
        chk("held cmd done", 64'(done_valid), 64'(1));
        chk("ready low in DONE", 64'(cmd_ready), 64'(0));
        @(negedge clk);
        chk("ready in IDLE", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        #1 cmd_valid = 0;
        @(negedge clk);
        chk("second cmd stb", 64'(wb_stb_o), 64'(1));
        for (int i = 0; i < 50 && !done_valid; i++) @(negedge clk);
        chk("second done", 64'({done_valid, done_status, done_count}), 64'({1'b1, 2'b00, 5'd1}));
        rd_ready = 0;
        @(negedge clk);

        for (int t = 0; t < 25; t++) begin
            w_len = $urandom_range(0, 15);
            w_ew = ($urandom % 4 == 0) ? int'($urandom_range(0, w_len)) : -1;
            case ($urandom % 3)
                0: w_rdm = 0;
                1: w_rdm = -1;
                default: w_rdm = 2;
            endcase
            run_burst(($urandom % 4 == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : $urandom, w_len, $urandom % 2 == 1,
                      $urandom_range(0, 3), w_ew, $urandom % 10 == 0, w_rdm, $urandom % 2 == 1, $urandom, 1'b1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passes, checks);
        $fatal(1);
    end
endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Wishbone classic-cycle initiator that moves a block of 32-bit words between a local command/stream interface and any Wishbone responder, e.g. a BRAM-backed register slave. One command describes a start address, a word count and a direction. The block then issues one single-word Wishbone cycle per word, and reports completion status with a timeout guard. It sits between user/DSP logic or a control processor bridge and the Wishbone interconnect.

## Interface
Parameters:
- LEN_BITS, 8, width of the word-count field; one burst carries up to 2^LEN_BITS words.
- TIMEOUT_CYCLES, 1024, cycles with STB high and no ACK/ERR before a word is abandoned; minimum 2.
- TO_BITS, 11, timeout counter width; must satisfy 2^TO_BITS > TIMEOUT_CYCLES.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_n_i  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  32  start byte address; bits [1:0] ignored and treated as 0.
- cmd_len  in  LEN_BITS  word count minus one.
- cmd_we  in  1  1 = write to bus, 0 = read from bus.
- wr_valid  in  1  write-data word present.
- wr_ready  out  1  write-data accepted.
- wr_data  in  32  write-data word.
- rd_valid  out  1  read-data word present.
- rd_ready  in  1  consumer accepts the read word.
- rd_data  out  32  read-data word.
- done_valid  out  1  one-cycle completion pulse.
- done_status  out  2  00 ok, 01 bus error, 10 timeout; valid with done_valid.
- done_count  out  LEN_BITS+1  words completed successfully; valid with done_valid.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone control.
- wb_adr_o  out  32  byte address, bits [1:0] = 0.
- wb_sel_o  out  4  always 4'hF.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i  in  1 each  responder acknowledge / error.

## Operation
FSM states:
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid: latch addr (with [1:0] cleared), len, we; clear the word counter.
  - Go to FETCH if we=1, else to BUS.
- **FETCH**
  - wr_ready=1.
  - On wr_valid: latch wr_data into the wb_dat_o register, then go to BUS.
- **BUS**
  - wb_cyc_o=wb_stb_o=1; wb_we_o=latched we; wb_adr_o=current address.
  - The timeout counter starts at 0 on entry and increments each cycle.
  - ACK has priority over ERR when both are high in the same cycle.
  - On wb_ack_i:
    - Read: capture wb_dat_i into rd_data, go to RD_OUT.
    - Write: go to NEXT.
  - On wb_err_i (no ACK): status 01, go to DONE.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ACK/ERR: status 10, go to DONE.
- **RD_OUT**
  - rd_valid=1; rd_data is held stable.
  - On rd_ready: go to NEXT.
- **NEXT** (one cycle, CYC/STB low)
  - Increment done_count; address += 4, wrapping modulo 2^32.
  - If the counter before increment equals len: status 00, go to DONE.
  - Otherwise go to FETCH (write) or BUS (read).
- **DONE**
  - done_valid=1 for exactly one cycle, then go to IDLE.

Rules:
- Only one Wishbone cycle is outstanding at any time.
- CYC and STB are never high outside BUS.
- STB is low for at least one cycle between words. Responders that block re-acceptance while an ACK is pending therefore see a clean edge.
- ACK/ERR outside BUS are ignored.
- A failed word is not counted. done_count equals the number of words ACKed (writes) or ACKed and delivered (reads).
- cmd_len = 2^LEN_BITS-1 gives a maximum burst of 2^LEN_BITS words; done_count is wide enough to hold it.

## Timing
- Reset values: state IDLE; cmd_ready=1; wr_ready, rd_valid, done_valid, wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_adr_o, wb_dat_o, rd_data, done_count = 0; done_status=00; wb_sel_o=4'hF.
- All outputs are registered or decoded from state; there are no combinational input-to-output paths.
- Command accepted at edge N:
  - Read: STB high from cycle N+1.
  - Write: FETCH in cycle N+1; STB high the cycle after wr_valid is seen.
- ACK at cycle M:
  - STB is low in cycle M+1.
  - For reads, rd_valid is high in cycle M+1.
- Per-word minimum cost (read, responder latency L, rd_ready tied high): L+3 cycles.
- Timeout: STB high for exactly TIMEOUT_CYCLES cycles, then CYC/STB low with done_valid in the next cycle.
- Reset asserted mid-burst:
  - Everything returns to reset values at that edge; CYC/STB drop immediately.
  - No done_valid pulse; the burst is discarded.
- cmd_valid held high during DONE is not accepted until IDLE (cmd_ready=0).

## Test plan
- Single read, len=0, addr 0x0000_0013, responder ACKs 2 cycles after STB with 0xDEADBEEF:
  - wb_adr_o=0x10.
  - rd_data=0xDEADBEEF.
  - done_status=00, done_count=1.
- 4-word write at 0x100, data 1..4, wr_valid toggled randomly:
  - Addresses 0x100/0x104/0x108/0x10C with matching data.
  - STB low ≥1 cycle between words.
  - done_count=4.
- 4-word read with rd_ready held low 5 cycles per word:
  - rd_data stable while stalled.
  - No new STB until the word is accepted.
- ERR on the 3rd word of a 5-word read: done_status=01, done_count=2.
- Responder silent: STB high exactly TIMEOUT_CYCLES cycles, then done_status=10.
- Reset mid-burst: drop wb_rst_n_i with STB high → CYC/STB 0 on the next edge, no done_valid; a fresh command then completes normally.
- Address wrap: addr 0xFFFF_FFFC, len=1 → second address 0x0000_0000.
